pipe_in_check: RTL and testbench
================================

# pipe_in_check

Sink-side checker for Pipe In verification. Consumes host words written over a Pipe In endpoint and compares each against the expected sequence from a local `pattern_gen`. It counts mismatches and captures the first failing word. A throttled virtual FIFO drives `pipe_in_ready`, mirroring the data-rate control used on the Pipe Out source side.

## Interface
Parameters:
- `READY_HEADROOM`, default 1024: minimum free virtual-FIFO space, in words, required for `pipe_in_ready`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `pipe_in_write`  in  1  host word valid this cycle.
- `pipe_in_data`  in  32  host word.
- `pipe_in_ready`  out  1  registered; high when ≥ READY_HEADROOM free slots.
- `throttle_set`  in  1  reload throttle rotator from `throttle_val`.
- `throttle_val`  in  32  drain-enable bit pattern.
- `pattern`  in  3  expected-data mode, passed to `pattern_gen`.
- `error_clear`  in  1  clears error state (not level, pattern, or word count).
- `word_count`  out  32  writes accepted since reset; wraps.
- `error_count`  out  32  mismatches; saturates at 0xFFFFFFFF.
- `first_err_valid`  out  1  sticky; a mismatch has been captured.
- `first_err_index`  out  32  0-based `word_count` value of the first mismatch.
- `first_err_expected`  out  32  expected word at the first mismatch.
- `first_err_received`  out  32  received word at the first mismatch.
- `overrun`  out  1  sticky; write occurred with level at 65535 and no drain.

## Operation
- **Expected data.**
  - `pattern_gen` (WIDTH 32) has `enable = pipe_in_write` and `mode = pattern`.
  - Its `dout` is the expected value for the word written this cycle and advances after each write.
- **Stage 1** (every write): register `pipe_in_data`, `dout`, the current `word_count`, and a valid bit. Increment `word_count`.
- **Stage 2** (stage-1 valid and data ≠ expected):
  - Increment `error_count`, saturating.
  - If `first_err_valid` = 0, load the three `first_err_*` registers and set `first_err_valid`.
  - Later mismatches do not overwrite the capture.
- **Virtual FIFO.** `level` is 16 bits and drains when `throttle[0]` = 1.
  - write only: level +1, held at 65535. A write while level = 65535 sets `overrun`; the word is still checked.
  - drain only: level −1, held at 0.
  - both, or neither: level unchanged.
- **Ready.** `pipe_in_ready` is registered as (level ≤ 65535 − READY_HEADROOM).
- **Throttle.**
  - Rotates right by 1 every cycle: `{t[0], t[31:1]}`.
  - `throttle_set` loads `throttle_val` instead of rotating.
- **Error clear.**
  - `error_clear` zeroes `error_count`, `first_err_*`, and `overrun`.
  - If a mismatch reaches stage 2 in the same cycle, clear wins and the mismatch is dropped.
  - Pipeline contents, `level`, `word_count`, and `pattern_gen` are untouched.
- **Reset.**
  - Outputs: all outputs 0, including `pipe_in_ready`.
  - Internal: `level` = 0, stage valid = 0, throttle ← `throttle_val`, `pattern_gen` reset.
  - Reset mid-stream discards in-flight words. Checking restarts from the pattern's initial value.

## Timing
- A write sampled at edge k appears in `word_count` after edge k.
- Its mismatch is reflected in `error_count` and `first_err_*` after edge k+1: two-cycle latency from data valid to visible.
- `pipe_in_ready` lags `level` by one cycle. With READY_HEADROOM > 0, the host may over-write by ≤1 word per cycle of lag without overflow.
- Back-to-back writes are supported every cycle. Stage 2 updates at most once per cycle.
- The first edge after `reset` falls sees `pipe_in_ready` = 1 (level 0).

## Structure
- Package `pipe_check_pkg` holds:
  - `DATA_W` = 32, `LEVEL_W` = 16, `LEVEL_MAX` = 16'hFFFF.
  - Pattern mode encodings shared with `pattern_gen` and the Pipe Out checker.
- Sub-module: `pattern_gen` (existing, WIDTH = 32) is the expected-data source. All other logic is flat in `pipe_in_check`.

## Test plan
- **Clean stream.** throttle 0xFFFFFFFF, 4096 correct words, one per cycle → `error_count` = 0, `first_err_valid` = 0, `word_count` = 4096, `overrun` = 0.
- **Single mismatch.** Word 100 XOR 0x1 → after 2 cycles `error_count` = 1, `first_err_index` = 100, expected/received differ by 0x1. Further bad words 200 and 300 → count 3, capture unchanged.
- **Ready threshold.** throttle 0x00000000, writes continuously → `pipe_in_ready` falls one cycle after level reaches 64512. Continuing to 65536 writes sets `overrun`, and level holds at 65535.
- **Drain rate.** throttle 0xAAAAAAAA, no writes from level 64 → level reaches 0 after 128 cycles and stays at 0.
- **Clear collision.** `error_clear` asserted the same cycle a mismatch reaches stage 2 → `error_count` = 0, `first_err_valid` = 0. A next mismatch captures normally.
- **Mid-stream reset.** Reset after 50 words, then restart the pattern from the beginning → no errors; `word_count` restarts at 0.

Source files
------------

// File: rtl/pipe_check_pkg.sv
// Shared widths, limits and pattern encodings for the Pipe In / Pipe Out checkers.
package pipe_check_pkg;

    localparam int DATA_W  = 32;
    localparam int LEVEL_W = 16;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 16'hFFFF;

    // Galois right-shift taps for the 32-bit pseudo-random mode.
    localparam logic [31:0] LFSR_TAPS = 32'hB4BC_D35C;
    localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

    typedef enum logic [2:0] {
        PAT_COUNT     = 3'd0,
        PAT_WALK1     = 3'd1,
        PAT_ALT       = 3'd2,
        PAT_LFSR      = 3'd3,
        PAT_INV_COUNT = 3'd4
    } pat_mode_e;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] expected;
        logic [DATA_W-1:0] index;
    } s1_t;

endpackage

// File: rtl/pattern_gen.sv
// Expected-data source: emits the current pattern word and advances once per enabled cycle.
module pattern_gen
    import pipe_check_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] dout
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(LFSR_TAPS);
    localparam logic [WIDTH-1:0] SEED = WIDTH'(LFSR_SEED);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            lfsr <= SEED;
        end else if (enable) begin
            cnt  <= cnt + 1'b1;
            lfsr <= {1'b0, lfsr[WIDTH-1:1]} ^ (lfsr[0] ? TAPS : '0);
        end
    end

    always_comb begin
        dout = cnt;
        case (pat_mode_e'(mode))
            PAT_COUNT:     dout = cnt;
            PAT_WALK1:     dout = WIDTH'(1) << cnt[$clog2(WIDTH)-1:0];
            PAT_ALT:       dout = cnt[0] ? {(WIDTH/2){2'b01}} : {(WIDTH/2){2'b10}};
            PAT_LFSR:      dout = lfsr;
            PAT_INV_COUNT: dout = ~cnt;
            default:       dout = cnt;
        endcase
    end

endmodule

// File: rtl/pipe_in_check.sv
// Pipe In sink checker: compares host words against pattern_gen, tracks errors,
// and paces the host through a throttled virtual FIFO.
module pipe_in_check
    import pipe_check_pkg::*;
#(
    parameter int unsigned READY_HEADROOM = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_in_write,
    input  logic [DATA_W-1:0] pipe_in_data,
    output logic              pipe_in_ready,
    input  logic              throttle_set,
    input  logic [31:0]       throttle_val,
    input  logic [2:0]        pattern,
    input  logic              error_clear,
    output logic [31:0]       word_count,
    output logic [31:0]       error_count,
    output logic              first_err_valid,
    output logic [31:0]       first_err_index,
    output logic [DATA_W-1:0] first_err_expected,
    output logic [DATA_W-1:0] first_err_received,
    output logic              overrun
);

    localparam int unsigned READY_LIMIT = 32'(LEVEL_MAX) - READY_HEADROOM;

    logic [DATA_W-1:0]  expected;
    logic [LEVEL_W-1:0] level;
    logic [31:0]        throttle;
    s1_t                s1;
    logic               drain;
    logic               mismatch;

    assign drain    = throttle[0];
    assign mismatch = s1.valid && (s1.data != s1.expected);

    pattern_gen #(.WIDTH(DATA_W)) u_pattern_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (pipe_in_write),
        .mode   (pattern),
        .dout   (expected)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1         <= '0;
            word_count <= '0;
        end else begin
            s1.valid    <= pipe_in_write;
            s1.data     <= pipe_in_data;
            s1.expected <= expected;
            s1.index    <= word_count;
            if (pipe_in_write)
                word_count <= word_count + 32'd1;
        end
    end

    // Clear beats a mismatch landing in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || error_clear) begin
            error_count        <= '0;
            first_err_valid    <= 1'b0;
            first_err_index    <= '0;
            first_err_expected <= '0;
            first_err_received <= '0;
            overrun            <= 1'b0;
        end else begin
            if (mismatch) begin
                if (error_count != 32'hFFFF_FFFF)
                    error_count <= error_count + 32'd1;
                if (!first_err_valid) begin
                    first_err_valid    <= 1'b1;
                    first_err_index    <= s1.index;
                    first_err_expected <= s1.expected;
                    first_err_received <= s1.data;
                end
            end
            if (pipe_in_write && !drain && level == LEVEL_MAX)
                overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level         <= '0;
            throttle      <= throttle_val;
            pipe_in_ready <= 1'b0;
        end else begin
            throttle      <= throttle_set ? throttle_val : {throttle[0], throttle[31:1]};
            pipe_in_ready <= (32'(level) <= READY_LIMIT);
            if (pipe_in_write && !drain && level != LEVEL_MAX)
                level <= level + 1'b1;
            else if (!pipe_in_write && drain && level != '0)
                level <= level - 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_in_check.sv
// Directed bench for pipe_in_check: clean stream, mismatch capture, ready/overrun,
// drain rate, clear collision, mid-stream reset and an alternate pattern mode.
module tb_pipe_in_check;
    import pipe_check_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pipe_in_write = 1'b0;
    logic [31:0] pipe_in_data = '0;
    logic        pipe_in_ready;
    logic        throttle_set = 1'b0;
    logic [31:0] throttle_val = '0;
    logic [2:0]  pattern = 3'd0;
    logic        error_clear = 1'b0;
    logic [31:0] word_count;
    logic [31:0] error_count;
    logic        first_err_valid;
    logic [31:0] first_err_index;
    logic [31:0] first_err_expected;
    logic [31:0] first_err_received;
    logic        overrun;

    int checks = 0;
    int failures = 0;

    pipe_in_check #(.READY_HEADROOM(1024)) dut (
        .clk                (clk),
        .reset              (reset),
        .pipe_in_write      (pipe_in_write),
        .pipe_in_data       (pipe_in_data),
        .pipe_in_ready      (pipe_in_ready),
        .throttle_set       (throttle_set),
        .throttle_val       (throttle_val),
        .pattern            (pattern),
        .error_clear        (error_clear),
        .word_count         (word_count),
        .error_count        (error_count),
        .first_err_valid    (first_err_valid),
        .first_err_index    (first_err_index),
        .first_err_expected (first_err_expected),
        .first_err_received (first_err_received),
        .overrun            (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_word(input logic [31:0] d);
        pipe_in_write = 1'b1;
        pipe_in_data  = d;
        tick();
        pipe_in_write = 1'b0;
    endtask

    task automatic do_reset(input logic [31:0] tv);
        reset         = 1'b1;
        throttle_val  = tv;
        pipe_in_write = 1'b0;
        throttle_set  = 1'b0;
        error_clear   = 1'b0;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        throttle_val = 32'hFFFF_FFFF;
        idle(2);
        checks++;
        if (pipe_in_ready !== 1'b0 || word_count !== 32'd0 || error_count !== 32'd0 ||
            first_err_valid !== 1'b0 || first_err_index !== 32'd0 || overrun !== 1'b0 ||
            first_err_expected !== 32'd0 || first_err_received !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b wc=%0d ec=%0d fev=%b ov=%b, required all zero",
                     pipe_in_ready, word_count, error_count, first_err_valid, overrun);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (pipe_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b required 1", pipe_in_ready);
        end
    endtask

    task automatic test_clean_stream();
        do_reset(32'hFFFF_FFFF);
        for (int i = 0; i < 4096; i++) write_word(32'(i));
        idle(2);
        checks++;
        if (error_count !== 32'd0 || first_err_valid !== 1'b0) begin
            failures++;
            $display("FAIL clean_errors: ec=%0d fev=%b required 0/0", error_count, first_err_valid);
        end
        checks++;
        if (word_count !== 32'd4096) begin
            failures++;
            $display("FAIL clean_word_count: got %0d required 4096", word_count);
        end
        checks++;
        if (overrun !== 1'b0 || dut.level !== 16'd0) begin
            failures++;
            $display("FAIL clean_level: ov=%b level=%0d required 0/0", overrun, dut.level);
        end
    endtask

    task automatic test_single_mismatch();
        logic [31:0] d;
        do_reset(32'hFFFF_FFFF);
        for (int i = 0; i < 400; i++) begin
            d = 32'(i);
            if (i == 100) d = d ^ 32'h1;
            if (i == 200) d = d ^ 32'h10;
            if (i == 300) d = d ^ 32'h100;
            write_word(d);
            if (i == 100) begin
                checks++;
                if (error_count !== 32'd0) begin
                    failures++;
                    $display("FAIL mismatch_latency_early: ec=%0d required 0", error_count);
                end
            end
            if (i == 101) begin
                checks++;
                if (error_count !== 32'd1 || first_err_valid !== 1'b1 || first_err_index !== 32'd100 ||
                    first_err_expected !== 32'd100 || first_err_received !== 32'd101) begin
                    failures++;
                    $display("FAIL mismatch_capture: ec=%0d v=%b idx=%0d exp=%h rcv=%h required 1/1/100/64/65",
                             error_count, first_err_valid, first_err_index, first_err_expected, first_err_received);
                end
            end
        end
        idle(2);
        checks++;
        if (error_count !== 32'd3 || first_err_index !== 32'd100 || first_err_received !== 32'd101) begin
            failures++;
            $display("FAIL mismatch_later: ec=%0d idx=%0d rcv=%0d required 3/100/101",
                     error_count, first_err_index, first_err_received);
        end
    endtask

    task automatic test_ready_threshold();
        do_reset(32'h0000_0000);
        for (int n = 1; n <= 65536; n++) begin
            write_word(32'(n - 1));
            if (n == 64512) begin
                checks++;
                if (pipe_in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL ready_before_threshold: got %b required 1", pipe_in_ready);
                end
            end
            if (n == 64513) begin
                checks++;
                if (pipe_in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL ready_after_threshold: got %b required 0", pipe_in_ready);
                end
            end
            if (n == 65535) begin
                checks++;
                if (overrun !== 1'b0 || dut.level !== 16'hFFFF) begin
                    failures++;
                    $display("FAIL full_no_overrun: ov=%b level=%0d required 0/65535", overrun, dut.level);
                end
            end
            if (n == 65536) begin
                checks++;
                if (overrun !== 1'b1 || dut.level !== 16'hFFFF) begin
                    failures++;
                    $display("FAIL overrun_set: ov=%b level=%0d required 1/65535", overrun, dut.level);
                end
            end
        end
        idle(2);
        checks++;
        if (word_count !== 32'd65536 || error_count !== 32'd0) begin
            failures++;
            $display("FAIL overrun_words_checked: wc=%0d ec=%0d required 65536/0", word_count, error_count);
        end
    endtask

    task automatic test_drain_rate();
        do_reset(32'h0000_0000);
        for (int i = 0; i < 64; i++) write_word(32'(i));
        throttle_set = 1'b1;
        throttle_val = 32'hAAAA_AAAA;
        tick();
        throttle_set = 1'b0;
        checks++;
        if (dut.level !== 16'd64) begin
            failures++;
            $display("FAIL drain_start: level=%0d required 64", dut.level);
        end
        idle(127);
        checks++;
        if (dut.level !== 16'd1) begin
            failures++;
            $display("FAIL drain_127: level=%0d required 1", dut.level);
        end
        tick();
        checks++;
        if (dut.level !== 16'd0) begin
            failures++;
            $display("FAIL drain_128: level=%0d required 0", dut.level);
        end
        idle(10);
        checks++;
        if (dut.level !== 16'd0) begin
            failures++;
            $display("FAIL drain_hold_zero: level=%0d required 0", dut.level);
        end
    endtask

    task automatic test_clear_collision();
        do_reset(32'hFFFF_FFFF);
        write_word(32'd0);
        write_word(32'd1);
        write_word(32'd2 ^ 32'hF0);
        error_clear = 1'b1;
        write_word(32'd3);
        error_clear = 1'b0;
        checks++;
        if (error_count !== 32'd0 || first_err_valid !== 1'b0) begin
            failures++;
            $display("FAIL clear_collision: ec=%0d fev=%b required 0/0", error_count, first_err_valid);
        end
        write_word(32'd4);
        write_word(32'd5);
        write_word(32'd6 ^ 32'h8);
        write_word(32'd7);
        idle(2);
        checks++;
        if (error_count !== 32'd1 || first_err_valid !== 1'b1 || first_err_index !== 32'd6 ||
            first_err_expected !== 32'd6 || first_err_received !== 32'd14) begin
            failures++;
            $display("FAIL clear_next_capture: ec=%0d v=%b idx=%0d exp=%0d rcv=%0d required 1/1/6/6/14",
                     error_count, first_err_valid, first_err_index, first_err_expected, first_err_received);
        end
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        checks++;
        if (error_count !== 32'd0 || first_err_valid !== 1'b0 || first_err_index !== 32'd0 ||
            word_count !== 32'd8) begin
            failures++;
            $display("FAIL clear_plain: ec=%0d v=%b idx=%0d wc=%0d required 0/0/0/8",
                     error_count, first_err_valid, first_err_index, word_count);
        end
    endtask

    task automatic test_mid_reset();
        do_reset(32'hFFFF_FFFF);
        for (int i = 0; i < 49; i++) write_word(32'(i));
        write_word(32'd49 ^ 32'h4);
        do_reset(32'hFFFF_FFFF);
        checks++;
        if (error_count !== 32'd0 || word_count !== 32'd0 || first_err_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_flush: ec=%0d wc=%0d v=%b required 0/0/0",
                     error_count, word_count, first_err_valid);
        end
        for (int i = 0; i < 20; i++) write_word(32'(i));
        idle(2);
        checks++;
        if (error_count !== 32'd0 || word_count !== 32'd20) begin
            failures++;
            $display("FAIL midreset_restart: ec=%0d wc=%0d required 0/20", error_count, word_count);
        end
    endtask

    task automatic test_alt_pattern();
        pattern = 3'd2;
        do_reset(32'hFFFF_FFFF);
        write_word(32'hAAAA_AAAA);
        write_word(32'h5555_5555);
        write_word(32'hAAAA_AAAA);
        write_word(32'h5555_5555);
        idle(2);
        checks++;
        if (error_count !== 32'd0) begin
            failures++;
            $display("FAIL alt_clean: ec=%0d required 0", error_count);
        end
        write_word(32'h5555_5555);
        idle(2);
        checks++;
        if (error_count !== 32'd1 || first_err_index !== 32'd4 ||
            first_err_expected !== 32'hAAAA_AAAA || first_err_received !== 32'h5555_5555) begin
            failures++;
            $display("FAIL alt_mismatch: ec=%0d idx=%0d exp=%h rcv=%h required 1/4/aaaaaaaa/55555555",
                     error_count, first_err_index, first_err_expected, first_err_received);
        end
        pattern = 3'd0;
    endtask

    initial begin
        test_reset();
        test_clean_stream();
        test_single_mismatch();
        test_clear_collision();
        test_mid_reset();
        test_alt_pattern();
        test_drain_rate();
        test_ready_threshold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
